fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- IF stage of the single-issue MIPS pipeline; owns the program counter and drives the 64-word instruction memory address.
- Captures the returned 32-bit instruction into the IF/ID pipeline register for decode.
- Handles decode-side stall, branch/jump redirect with bubble insertion, and a sticky halt.

Parameters:
- RESET_PC, 32'h00000000, byte address loaded into PC on reset.
- IMEM_AW, 6, instruction memory word-address width; sets the imem_addr width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- imem_addr  output  IMEM_AW  word address to instruction memory; equals pc[IMEM_AW+1:2], combinational from pc.
- imem_data  input  32  instruction from memory; combinational, valid in the same cycle.
- stall  input  1  decode stall; hold PC and IF/ID register.
- redirect  input  1  branch taken or jump resolved in ID.
- redirect_pc  input  32  byte target address for redirect.
- halt  input  1  stop fetching until reset.
- pc  output  32  current fetch PC.
- if_instr  output  32  IF/ID instruction.
- if_pc4  output  32  IF/ID PC+4 of the captured instruction.
- if_valid  output  1  IF/ID entry holds a real instruction.
- halted  output  1  fetch is in the HALTED state.

Behaviour:
- Reset: at any edge with rst_n=0, regardless of other inputs or state: pc=RESET_PC, if_instr=0, if_pc4=0, if_valid=0, halted=0, state=BOOT.
- FSM states: BOOT, RUN, HALTED.
  - BOOT lasts one cycle, with no capture and pc held. It then goes to RUN, or to HALTED if halt=1.
  - RUN: halt=1 moves to HALTED at the next edge.
  - HALTED: exits only on reset.
- Action priority each edge in RUN is halt > redirect > stall > advance.
  - halt: if_valid<=0, if_instr<=0, pc held, halted<=1.
  - redirect: pc<=redirect_pc with bits [1:0] forced to 0; if_valid<=0; if_instr<=0 (bubble); if_pc4<=0. A redirect overrides a simultaneous stall.
  - stall (no redirect): pc, if_instr, if_pc4 and if_valid all hold.
  - advance: if_instr<=imem_data; if_pc4<=pc+4; if_valid<=1; pc<=pc+4.
- Latency: one cycle from imem_addr to if_instr.
  - First valid instruction (word 0) appears on the second edge after rst_n rises.
- Wrap-around:
  - pc is a full 32-bit register; 32'hFFFFFFFC+4 wraps to 0.
  - imem_addr uses pc[IMEM_AW+1:2] only, so fetch past word 63 aliases to word 0.
- Redirect in HALTED or BOOT is ignored.
- Stall in HALTED has no effect; outputs stay as bubble.
- Arithmetic: all additions are 32-bit unsigned; carry is discarded.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, adds output ports fetch_cnt[31:0] and bubble_cnt[31:0]. Both reset to 0.
  - fetch_cnt increments on every advance.
  - bubble_cnt increments on every redirect, and on every cycle in RUN with stall=1.
  - Both wrap at 2^32.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package: FSM state typedef (BOOT/RUN/HALTED, 2-bit), NOP constant 32'h00000000, PC_INC constant 4.
- One sub-module: if_id_reg. It holds if_instr/if_pc4/if_valid and takes load, bubble and hold controls. The PC/FSM logic stays in fetch_stage.

Test Plan:
- Imem preload: word0=32'h20020003, word1=32'h20070003, word2=32'h00471820.
- Reset release, no stall:
  - Edge 1 after rst_n=1: BOOT, if_valid=0.
  - Edge 2: if_instr=32'h20020003, if_pc4=4.
  - Edge 3: if_instr=32'h20070003, pc=8.
- Stall at pc=8 for 3 cycles: if_instr stays 32'h20070003 and pc stays 8; release, then the next edge gives if_instr=32'h00471820.
- redirect=1 and stall=1 at once, redirect_pc=32'h00000007:
  - Next edge: pc=4, if_valid=0, if_instr=0.
  - Following edge: if_instr=32'h20070003.
- Wrap: redirect to 32'h000000FC, advance twice; imem_addr goes 63 then 0, pc=32'h00000100, second capture is word 0 = 32'h20020003.
- halt in RUN: halted=1 and if_valid=0 from the next edge. Redirect and stall pulses are then ignored. Assert rst_n=0 for one edge: pc=0, halted=0.
- With FETCH_PERF_CNT_EN: 5 advances, 1 redirect and 2 stall cycles give fetch_cnt=5 and bubble_cnt=3.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the IF stage: FSM state encoding, bubble word and PC step.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP    = 32'h0000_0000;
  localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register. Priority is bubble > hold > load; with no control asserted it holds.
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        bubble_i,
  input  logic        hold_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc4_i,
  input  logic [31:0] bubble_pc4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc4_o,
  output logic        valid_o
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (bubble_i) begin
      // The caller decides whether the bubble also clears the PC+4 field.
      instr_d = NOP;
      pc4_d   = bubble_pc4_i;
      valid_d = 1'b0;
    end else if (load_i && !hold_i) begin
      instr_d = instr_i;
      pc4_d   = pc4_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_q <= NOP;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS IF stage: PC, BOOT/RUN/HALTED control and IF/ID capture.
// Optional performance counters are enabled with `define FETCH_PERF_CNT_EN.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_data,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  input  logic               halt,
  output logic [31:0]        pc,
  output logic [31:0]        if_instr,
  output logic [31:0]        if_pc4,
  output logic               if_valid,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]        fetch_cnt,
  output logic [31:0]        bubble_cnt,
`endif
  output logic               halted
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pc_plus4;
  logic         load, bubble, hold;
  logic [31:0]  bubble_pc4;
  logic         adv_evt, bub_evt;

  assign pc_plus4 = pc_q + PC_INC;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    load       = 1'b0;
    bubble     = 1'b0;
    hold       = 1'b0;
    bubble_pc4 = if_pc4;
    adv_evt    = 1'b0;
    bub_evt    = 1'b0;
    case (state_q)
      ST_BOOT: state_d = halt ? ST_HALTED : ST_RUN;
      ST_RUN: begin
        if (halt) begin
          state_d = ST_HALTED;
          bubble  = 1'b1;
        end else if (redirect) begin
          pc_d       = {redirect_pc[31:2], 2'b00};
          bubble     = 1'b1;
          bubble_pc4 = 32'd0;
          bub_evt    = 1'b1;
        end else if (stall) begin
          hold    = 1'b1;
          bub_evt = 1'b1;
        end else begin
          load    = 1'b1;
          pc_d    = pc_plus4;
          adv_evt = 1'b1;
        end
      end
      // HALTED is left only through reset.
      default: state_d = ST_HALTED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  if_id_reg u_if_id (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (load),
    .bubble_i     (bubble),
    .hold_i       (hold),
    .instr_i      (imem_data),
    .pc4_i        (pc_plus4),
    .bubble_pc4_i (bubble_pc4),
    .instr_o      (if_instr),
    .pc4_o        (if_pc4),
    .valid_o      (if_valid)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, bubble_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
    end else begin
      if (adv_evt) fetch_cnt_q  <= fetch_cnt_q + 32'd1;
      if (bub_evt) bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt  = fetch_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`else
  logic unused_evt;
  assign unused_evt = adv_evt ^ bub_evt;
`endif

  assign imem_addr = pc_q[IMEM_AW+1:2];
  assign pc        = pc_q;
  assign halted    = (state_q == ST_HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a cycle-level behavioural model and literal spot checks.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  imem_addr;
  logic [31:0] imem_data;
  logic        stall, redirect, halt;
  logic [31:0] redirect_pc;
  logic [31:0] pc, if_instr, if_pc4;
  logic        if_valid, halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, bubble_cnt;
`endif

  logic [31:0] mem [64];
  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // model state
  int          m_mode;  // 0 boot, 1 run, 2 halted
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  logic [31:0] m_fc, m_bc;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr];

  fetch_stage #(.RESET_PC(32'h0), .IMEM_AW(6)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .pc(pc), .if_instr(if_instr), .if_pc4(if_pc4), .if_valid(if_valid),
`ifdef FETCH_PERF_CNT_EN
    .fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt),
`endif
    .halted(halted)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_mode = 0; m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      m_fc = 0; m_bc = 0;
    end else if (m_mode == 0) begin
      m_mode = halt ? 2 : 1;
    end else if (m_mode == 1) begin
      if (halt) begin
        m_mode = 2; m_valid = 1'b0; m_instr = 32'h0;
      end else if (redirect) begin
        m_pc = (redirect_pc / 4) * 4;
        m_valid = 1'b0; m_instr = 32'h0; m_pc4 = 32'h0;
        m_bc = m_bc + 1;
      end else if (stall) begin
        m_bc = m_bc + 1;
      end else begin
        m_instr = mem[(m_pc / 4) % 64];
        m_pc4 = m_pc + 4;
        m_valid = 1'b1;
        m_pc = m_pc + 4;
        m_fc = m_fc + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_pc", pc, m_pc);
      check("m_imem_addr", {26'd0, imem_addr}, (m_pc / 4) % 64);
      check("m_if_instr", if_instr, m_instr);
      check("m_if_pc4", if_pc4, m_pc4);
      check("m_if_valid", {31'd0, if_valid}, {31'd0, m_valid});
      check("m_halted", {31'd0, halted}, (m_mode == 2) ? 32'd1 : 32'd0);
`ifdef FETCH_PERF_CNT_EN
      check("m_fetch_cnt", fetch_cnt, m_fc);
      check("m_bubble_cnt", bubble_cnt, m_bc);
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time expired");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
    mem[0] = 32'h20020003; mem[1] = 32'h20070003; mem[2] = 32'h00471820;
    mem[63] = 32'hCAFE_0063;
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; halt = 1'b0; redirect_pc = 32'h0;
    @(posedge clk);
    chk_en = 1'b1;
    step(2);
    check("rst_pc", pc, 32'h0);
    check("rst_valid", {31'd0, if_valid}, 32'd0);
    check("rst_instr", if_instr, 32'h0);
    check("rst_halted", {31'd0, halted}, 32'd0);

    rst_n = 1'b1;
    step(1);
    check("boot_valid", {31'd0, if_valid}, 32'd0);
    check("boot_pc", pc, 32'h0);
    step(1);
    check("e2_instr", if_instr, 32'h20020003);
    check("e2_pc4", if_pc4, 32'd4);
    step(1);
    check("e3_instr", if_instr, 32'h20070003);
    check("e3_pc", pc, 32'd8);

    stall = 1'b1;
    step(3);
    check("stall_pc", pc, 32'd8);
    check("stall_instr", if_instr, 32'h20070003);
    stall = 1'b0;
    step(1);
    check("unstall_instr", if_instr, 32'h00471820);

    redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h7;
    step(1);
    check("redir_pc", pc, 32'd4);
    check("redir_valid", {31'd0, if_valid}, 32'd0);
    check("redir_instr", if_instr, 32'h0);
    redirect = 1'b0; stall = 1'b0;
    step(1);
    check("redir_next_instr", if_instr, 32'h20070003);

    redirect = 1'b1; redirect_pc = 32'h0000_00FC;
    step(1);
    check("wrap_addr63", {26'd0, imem_addr}, 32'd63);
    redirect = 1'b0;
    step(1);
    check("wrap_addr0", {26'd0, imem_addr}, 32'd0);
    check("wrap_instr63", if_instr, 32'hCAFE_0063);
    step(1);
    check("wrap_pc", pc, 32'h0000_0104);
    check("wrap_instr0", if_instr, 32'h20020003);

    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    step(1);
    check("top_pc", pc, 32'hFFFF_FFFC);
    redirect = 1'b0;
    step(1);
    check("pc32_wrap", pc, 32'h0);
    check("pc4_32_wrap", if_pc4, 32'h0);
    step(1);
    check("post_wrap_pc", pc, 32'd4);

    halt = 1'b1;
    step(1);
    check("halt_halted", {31'd0, halted}, 32'd1);
    check("halt_valid", {31'd0, if_valid}, 32'd0);
    halt = 1'b0; redirect = 1'b1; redirect_pc = 32'h40; stall = 1'b1;
    step(2);
    redirect = 1'b0; stall = 1'b0;
    step(1);
    check("halt_pc_held", pc, 32'd4);
    check("halt_sticky", {31'd0, halted}, 32'd1);
    check("halt_instr", if_instr, 32'h0);

    rst_n = 1'b0;
    step(1);
    check("rerst_pc", pc, 32'h0);
    check("rerst_halted", {31'd0, halted}, 32'd0);
    rst_n = 1'b1; halt = 1'b1;
    step(1);
    check("boot_halt", {31'd0, halted}, 32'd1);
    halt = 1'b0; redirect = 1'b1; redirect_pc = 32'h20;
    step(2);
    redirect = 1'b0;
    check("boot_halt_pc", pc, 32'h0);
    check("boot_halt_valid", {31'd0, if_valid}, 32'd0);

    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(3);
    stall = 1'b1;
    step(2);
    stall = 1'b0; redirect = 1'b1; redirect_pc = 32'h8;
    step(1);
    redirect = 1'b0;
    step(3);
    check("perf_pc", pc, 32'h14);
    check("perf_instr", if_instr, 32'h1000_0004);
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetch_cnt", fetch_cnt, 32'd5);
    check("perf_bubble_cnt", bubble_cnt, 32'd3);
`endif

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
